// File: rtl/i2c_config_sequencer.sv
// Register-write sequencer: streams a programmable table of register words to a
// byte-level I2C controller with NACK retry, inter-write gap and status reporting.
module i2c_config_sequencer #(
   parameter int unsigned ADDR_BITS   = 4,
   parameter int unsigned REG_WIDTH   = 16,
   parameter logic [7:0]  DEV_BYTE    = 8'h34,
   parameter int unsigned MAX_RETRIES = 3,
   parameter int unsigned GAP_CYCLES  = 16,
   parameter bit          AUTO_START  = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   go,
   input  logic [ADDR_BITS-1:0]   last_index,
   input  logic                   tbl_we,
   input  logic [ADDR_BITS-1:0]   tbl_addr,
   input  logic [REG_WIDTH-1:0]   tbl_wdata,
   output logic [8+REG_WIDTH-1:0] i2c_data,
   output logic                   i2c_start,
   input  logic                   i2c_done,
   input  logic                   i2c_ack,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [ADDR_BITS-1:0]   index,
   output logic [1:0]             retries
);

   localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
   localparam int unsigned DATA_W = 8 + REG_WIDTH;
   localparam int unsigned GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT, S_GAP, S_DONE, S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_BITS-1:0]  index_q, index_d;
   logic [ADDR_BITS-1:0]  last_q, last_d;
   logic [1:0]            retries_q, retries_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  auto_q, auto_d;
   logic                  idle_like_c;
   logic                  go_acc_c;
   logic                  tbl_wr_c;

   logic [REG_WIDTH-1:0]  tbl_q [DEPTH];

   // Next-state, counters and registered-output computation.
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      last_d    = last_q;
      retries_d = retries_q;
      gap_cnt_d = gap_cnt_q;
      data_d    = data_q;
      auto_d    = 1'b0;

      idle_like_c = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
      // Reset excluded so the table can be preloaded while reset is held.
      go_acc_c    = idle_like_c && !reset && (go || auto_q);
      tbl_wr_c    = tbl_we && idle_like_c && !go_acc_c;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (go_acc_c) begin
               last_d    = last_index;
               index_d   = '0;
               retries_d = '0;
               state_d   = S_START;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (i2c_done) begin
               if (i2c_ack) begin
                  if (index_q == last_q) begin
                     state_d = S_DONE;
                  end else begin
                     index_d   = index_q + ADDR_BITS'(1);
                     retries_d = '0;
                     state_d   = (GAP_CYCLES == 0) ? S_START : S_GAP;
                     gap_cnt_d = '0;
                  end
               end else if (retries_q == 2'(MAX_RETRIES)) begin
                  state_d = S_ERROR;
               end else begin
                  if (retries_q != 2'd3) retries_d = retries_q + 2'd1;
                  state_d   = (GAP_CYCLES == 0) ? S_START : S_GAP;
                  gap_cnt_d = '0;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYCLES)) state_d = S_START;
            else                                 gap_cnt_d = gap_cnt_q + GAP_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // START is always left after one cycle, so this fires on every entry.
      if (state_d == S_START) data_d = {DEV_BYTE, tbl_q[index_d]};

      start_d = (state_d == S_START);
      busy_d  = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_GAP);
      done_d  = (state_d == S_DONE);
      error_d = (state_d == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         last_q    <= '0;
         retries_q <= '0;
         gap_cnt_q <= '0;
         data_q    <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         auto_q    <= AUTO_START;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         last_q    <= last_d;
         retries_q <= retries_d;
         gap_cnt_q <= gap_cnt_d;
         data_q    <= data_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         auto_q    <= auto_d;
      end
   end

   // Table storage survives reset.
   always_ff @(posedge clk) begin
      if (tbl_wr_c) tbl_q[tbl_addr] <= tbl_wdata;
   end

   assign i2c_data  = data_q;
   assign i2c_start = start_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign index     = index_q;
   assign retries   = retries_q;

endmodule
